// File: rtl/md_unit.sv
// md_unit -- EX-stage multiply/divide unit.
//
// Runs mult/multu/div/divu as multi-cycle operations and mthi/mtlo as
// single-cycle writes to HI/LO. The arithmetic result is computed
// combinationally when the operation is accepted and parked in HI_t/LO_t.
// A down-counter models the latency, and the result is committed to HI/LO
// on the final RUN edge.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   A      : operand rs (dividend / multiplicand / mthi,mtlo source)
//   B      : operand rt (divisor / multiplier)
//   MDUCtr : 000 none, 001 mult, 010 multu, 011 div, 100 divu,
//            101 mthi, 110 mtlo, 111 none
//   Start  : MDUCtr is valid this cycle
//   Busy   : an operation is in flight
//   HI, LO : architectural HI/LO registers
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUCtr,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   hi_t_q, lo_t_q;
  logic          ok_q;

  logic          is_mul, is_div, launch, commit;
  logic          wr_hi, wr_lo;
  logic [63:0]   prod;
  logic [31:0]   res_hi, res_lo;
  logic          res_ok;

  assign is_mul = (MDUCtr == OP_MULT) || (MDUCtr == OP_MULTU);
  assign is_div = (MDUCtr == OP_DIV)  || (MDUCtr == OP_DIVU);

  // Combinational result of the operation presented on A/B/MDUCtr.
  always_comb begin
    prod   = '0;
    res_hi = '0;
    res_lo = '0;
    res_ok = 1'b1;
    case (MDUCtr)
      OP_MULT: begin
        prod   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      OP_MULTU: begin
        prod   = {32'b0, A} * {32'b0, B};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      OP_DIV: begin
        if (B == 32'b0) begin
          res_ok = 1'b0;  // divide by zero: run the latency, commit nothing
        end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          // The only signed overflow case; the quotient wraps to itself.
          res_lo = 32'h8000_0000;
          res_hi = 32'h0;
        end else begin
          res_lo = $signed(A) / $signed(B);
          res_hi = $signed(A) % $signed(B);
        end
      end
      OP_DIVU: begin
        if (B == 32'b0) begin
          res_ok = 1'b0;
        end else begin
          res_lo = A / B;
          res_hi = A % B;
        end
      end
      default: ;
    endcase
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (Start && (is_mul || is_div)) begin
          state_d = RUN;
          cnt_d   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Any Start seen outside IDLE is dropped here.
  always_comb begin
    Busy   = (state_q == RUN);
    launch = (state_q == IDLE) && Start && (is_mul || is_div);
    commit = (state_q == RUN) && (cnt_q == CW'(1)) && ok_q;
    wr_hi  = (state_q == IDLE) && Start && (MDUCtr == OP_MTHI);
    wr_lo  = (state_q == IDLE) && Start && (MDUCtr == OP_MTLO);
  end

  // Datapath: staged result and architectural HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_t_q <= '0;
      lo_t_q <= '0;
      ok_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (launch) begin
        hi_t_q <= res_hi;
        lo_t_q <= res_lo;
        ok_q   <= res_ok;
      end
      if (commit) begin
        hi_q <= hi_t_q;
        lo_q <= lo_t_q;
      end else begin
        if (wr_hi) hi_q <= A;
        if (wr_lo) lo_q <= A;
      end
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDUCtr;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int passes = 0;

  // Reference HI/LO as the architecture should see them.
  logic [31:0] hi_m, lo_m;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUCtr(MDUCtr),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Behavioural reference: results from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo, output int busy_n);
    longint sa, sb, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    busy_n = 0;
    case (op)
      3'd1: begin up = 64'(sa * sb); hi = up[63:32]; lo = up[31:0]; busy_n = MULT_N; end
      3'd2: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; busy_n = MULT_N; end
      3'd3: begin
        busy_n = DIV_N;
        if (b != 0) begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
      end
      3'd4: begin
        busy_n = DIV_N;
        if (b != 0) begin lo = a / b; hi = a % b; end
      end
      3'd5: hi = a;
      3'd6: lo = a;
      default: ;
    endcase
  endtask

  // Issue one op; optionally inject a second Start during Busy (inj_at>0).
  // Returns observed Busy cycles and whether HI/LO ever moved while busy.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int inj_at, input logic [2:0] inj_op, input logic [31:0] inj_a,
                       output int n_busy, output bit moved);
    logic [31:0] h0, l0;
    h0 = HI; l0 = LO;
    moved = 0;
    MDUCtr = op; A = a; B = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; A = $urandom; B = $urandom; MDUCtr = 3'($urandom);
    n_busy = 0;
    while (Busy && n_busy < 40) begin
      if (HI !== h0 || LO !== l0) moved = 1;
      n_busy++;
      Start = (inj_at > 0 && n_busy == inj_at);
      if (Start) begin MDUCtr = inj_op; A = inj_a; end
      @(negedge clk);
      Start = 1'b0;
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    int          busy;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int nb, exp_n;
    bit mv;
    logic [31:0] eh, el;

    vecs[0]  = '{"mult_m2x3",   3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N};
    vecs[1]  = '{"multu_max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT_N};
    vecs[2]  = '{"div_m7_2",    3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
    vecs[3]  = '{"divu_7_2",    3'd4, 32'd7,         32'd2,         32'd1,         32'd3,         DIV_N};
    vecs[4]  = '{"div_ovf",     3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, DIV_N};
    vecs[5]  = '{"div_by0",     3'd3, 32'h1234,      32'h0,         32'h0,         32'h8000_0000, DIV_N};
    vecs[6]  = '{"mthi",        3'd5, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'h8000_0000, 0};
    vecs[7]  = '{"mtlo",        3'd6, 32'h0000_DEAD, 32'h0,         32'h1234_5678, 32'h0000_DEAD, 0};
    vecs[8]  = '{"op_none",     3'd0, 32'hAAAA_AAAA, 32'h5,         32'h1234_5678, 32'h0000_DEAD, 0};
    vecs[9]  = '{"op_rsvd",     3'd7, 32'hBBBB_BBBB, 32'h5,         32'h1234_5678, 32'h0000_DEAD, 0};
    vecs[10] = '{"divu_by0",    3'd4, 32'h99,        32'h0,         32'h1234_5678, 32'h0000_DEAD, DIV_N};

    reset = 1'b0; Start = 1'b0; A = '0; B = '0; MDUCtr = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_busy", {31'b0, Busy}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Start=0 with an op on the bus must do nothing.
    MDUCtr = 3'd5; A = 32'hFACE; Start = 1'b0;
    @(negedge clk);
    chk("nostart_hi", HI, 32'h0);
    chk("nostart_busy", {31'b0, Busy}, 32'h0);

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 0, 3'd0, 32'h0, nb, mv);
      chk({vecs[i].name, "_busy"}, 32'(nb), 32'(vecs[i].busy));
      chk({vecs[i].name, "_hold"}, {31'b0, mv}, 32'h0);
      chk({vecs[i].name, "_hi"}, HI, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, LO, vecs[i].lo);
      $display("vec %s op=%0d a=%08h b=%08h busy=%0d hi=%08h lo=%08h", vecs[i].name,
               vecs[i].op, vecs[i].a, vecs[i].b, nb, HI, LO);
    end
    hi_m = HI; lo_m = LO;

    // Collision: mtlo during a mult is ignored; mult result wins.
    issue(3'd1, 32'd3, 32'd4, 2, 3'd6, 32'hDEAD, nb, mv);
    chk("coll_busy", 32'(nb), 32'(MULT_N));
    chk("coll_hi", HI, 32'h0);
    chk("coll_lo", LO, 32'd12);
    $display("collision mult 3*4 + mtlo 0xDEAD: busy=%0d hi=%08h lo=%08h", nb, HI, LO);

    // Collision: a second div during a div does not restart or replace it.
    issue(3'd4, 32'd100, 32'd7, 3, 3'd4, 32'd9, nb, mv);
    chk("coll2_busy", 32'(nb), 32'(DIV_N));
    chk("coll2_lo", LO, 32'd14);
    chk("coll2_hi", HI, 32'd2);
    $display("collision divu 100/7 + divu: busy=%0d hi=%08h lo=%08h", nb, HI, LO);
    hi_m = HI; lo_m = LO;

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 4) == 0) b = 32'($urandom_range(1, 9));
      model(op, a, b, hi_m, lo_m, exp_n);
      issue(op, a, b, 0, 3'd0, 32'h0, nb, mv);
      chk("rnd_busy", 32'(nb), 32'(exp_n));
      chk("rnd_hold", {31'b0, mv}, 32'h0);
      chk("rnd_hi", HI, hi_m);
      chk("rnd_lo", LO, lo_m);
      $display("rnd %0d op=%0d a=%08h b=%08h busy=%0d hi=%08h lo=%08h", i, op, a, b, nb, HI, LO);
    end

    // Reset in the middle of a div: immediate clear, no later commit.
    MDUCtr = 3'd4; A = 32'd50; B = 32'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, Busy}, 32'h0);
    chk("midrst_hi", HI, 32'h0);
    chk("midrst_lo", LO, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    eh = 32'h0; el = 32'h0;
    nb = 0;
    for (int c = 0; c < DIV_N + 5; c++) begin
      @(negedge clk);
      if (Busy) nb++;
    end
    chk("midrst_nobusy", 32'(nb), 32'h0);
    chk("midrst_nocommit_hi", HI, eh);
    chk("midrst_nocommit_lo", LO, el);
    $display("mid-op reset: busy_after=%0d hi=%08h lo=%08h", nb, HI, LO);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
